mesi_state_function: RTL and testbench



---
 rtl/mesi_pkg.sv | 61 ++++++
 rtl/mesi_decode.sv | 68 ++++++
 rtl/mesi_state_function.sv | 59 +++++
 tb/tb_mesi_state_function.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mesi_pkg.sv
// Shared MESI encodings and the pure next-state rule used by the coherence engine.
package mesi_pkg;

    typedef enum logic [1:0] {
        ST_M = 2'b00,
        ST_E = 2'b01,
        ST_S = 2'b10,
        ST_I = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10
    } snoop_t;

    typedef enum logic [2:0] {
        BUS_NONE       = 3'd0,
        BUS_READ       = 3'd1,
        BUS_WRITE      = 3'd2,
        BUS_INVALIDATE = 3'd3,
        BUS_RWIM       = 3'd4
    } bus_op_t;

    typedef enum logic [2:0] {
        L1_NONE           = 3'd0,
        L1_GETLINE        = 3'd1,
        L1_SENDLINE       = 3'd2,
        L1_INVALIDATELINE = 3'd3,
        L1_EVICTLINE      = 3'd4
    } l1_msg_t;

    localparam logic [3:0] CMD_L1_READ       = 4'd0;
    localparam logic [3:0] CMD_L1_WRITE      = 4'd1;
    localparam logic [3:0] CMD_L1_INST_READ  = 4'd2;
    localparam logic [3:0] CMD_SNOOP_INVAL   = 4'd3;
    localparam logic [3:0] CMD_SNOOP_READ    = 4'd4;
    localparam logic [3:0] CMD_SNOOP_WRITE   = 4'd5;
    localparam logic [3:0] CMD_SNOOP_RFO     = 4'd6;
    localparam logic [3:0] CMD_CLEAR         = 4'd8;
    localparam logic [3:0] CMD_PRINT_CACHE   = 4'd9;

    // A read miss is resolved to E here; the snoop-dependent demotion to S is done by the decoder.
    function automatic state_t mesi_next_state(input logic [1:0] state, input logic [3:0] cmd);
        state_t cur;
        cur = state_t'(state);
        case (cmd)
            CMD_L1_READ, CMD_L1_INST_READ: return (cur == ST_I) ? ST_E : cur;
            CMD_L1_WRITE:                  return ST_M;
            CMD_SNOOP_INVAL:               return (cur == ST_S) ? ST_I : cur;
            CMD_SNOOP_READ:                return (cur == ST_M || cur == ST_E) ? ST_S : cur;
            CMD_SNOOP_RFO, CMD_CLEAR:      return ST_I;
            default:                       return cur;
        endcase
    endfunction

    function automatic logic [3:0] mesi_next(input logic [1:0] state, input logic [3:0] cmd);
        return {2'b00, mesi_next_state(state, cmd)};
    endfunction

endpackage

// File: rtl/mesi_decode.sv
// Combinational MESI action table: next state, bus operation, snoop response and L1 message.
module mesi_decode
    import mesi_pkg::*;
(
    input  logic [1:0] present_state,
    input  logic [3:0] command,
    input  logic [1:0] snoop_result,
    output logic [1:0] next_state,
    output logic [2:0] bus_op,
    output logic [1:0] put_snoop,
    output logic [2:0] l1_msg,
    output logic       protocol_err
);

    logic shared;

    // Code 2'b11 on the snoop bus is deliberately treated as no hit.
    assign shared = (snoop_result == SNP_HIT) || (snoop_result == SNP_HITM);

    always_comb begin
        next_state   = mesi_next_state(present_state, command);
        bus_op       = BUS_NONE;
        put_snoop    = SNP_NOHIT;
        l1_msg       = L1_NONE;
        protocol_err = 1'b0;
        case (command)
            CMD_L1_READ, CMD_L1_INST_READ: begin
                l1_msg = L1_SENDLINE;
                if (present_state == ST_I) begin
                    bus_op = BUS_READ;
                    if (shared) next_state = ST_S;
                end
            end
            CMD_L1_WRITE: begin
                if (present_state == ST_S)      bus_op = BUS_INVALIDATE;
                else if (present_state == ST_I) bus_op = BUS_RWIM;
            end
            CMD_SNOOP_INVAL: begin
                if (present_state == ST_S)
                    l1_msg = L1_INVALIDATELINE;
                else if (present_state == ST_M || present_state == ST_E)
                    protocol_err = 1'b1;
            end
            CMD_SNOOP_READ: begin
                if (present_state == ST_M) begin
                    put_snoop = SNP_HITM;
                    bus_op    = BUS_WRITE;
                    l1_msg    = L1_GETLINE;
                end else if (present_state != ST_I) begin
                    put_snoop = SNP_HIT;
                end
            end
            CMD_SNOOP_RFO: begin
                if (present_state == ST_M) begin
                    put_snoop = SNP_HITM;
                    bus_op    = BUS_WRITE;
                    l1_msg    = L1_EVICTLINE;
                end else if (present_state != ST_I) begin
                    put_snoop = SNP_HIT;
                    l1_msg    = L1_INVALIDATELINE;
                end
            end
            CMD_SNOOP_WRITE, CMD_CLEAR, CMD_PRINT_CACHE: ;
            default: protocol_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/mesi_state_function.sv
// Per-line MESI coherence engine: one request per cycle, results registered one cycle later.
module mesi_state_function
    import mesi_pkg::*;
#(
    parameter int unsigned STATE_W = 2,
    parameter int unsigned CMD_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [STATE_W-1:0] present_state,
    input  logic [CMD_W-1:0]   command,
    input  logic [1:0]         snoop_result,
    output logic               rsp_valid,
    output logic [STATE_W-1:0] result_state,
    output logic [2:0]         bus_op,
    output logic [1:0]         put_snoop,
    output logic [2:0]         l1_msg,
    output logic               protocol_err
);

    logic [1:0] dec_state;
    logic [2:0] dec_bus_op;
    logic [1:0] dec_put_snoop;
    logic [2:0] dec_l1_msg;
    logic       dec_err;

    mesi_decode u_decode (
        .present_state (present_state),
        .command       (command),
        .snoop_result  (snoop_result),
        .next_state    (dec_state),
        .bus_op        (dec_bus_op),
        .put_snoop     (dec_put_snoop),
        .l1_msg        (dec_l1_msg),
        .protocol_err  (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            result_state <= ST_I;
            bus_op       <= BUS_NONE;
            put_snoop    <= SNP_NOHIT;
            l1_msg       <= L1_NONE;
            protocol_err <= 1'b0;
        end else begin
            rsp_valid <= req_valid;
            if (req_valid) begin
                result_state <= dec_state;
                bus_op       <= dec_bus_op;
                put_snoop    <= dec_put_snoop;
                l1_msg       <= dec_l1_msg;
                protocol_err <= dec_err;
            end
        end
    end

endmodule

// File: tb/tb_mesi_state_function.sv
// Randomized and table-sweep bench for mesi_state_function against a lookup-table reference model.
module tb_mesi_state_function;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] present_state;
    logic [3:0] command;
    logic [1:0] snoop_result;
    logic       rsp_valid;
    logic [1:0] result_state;
    logic [2:0] bus_op;
    logic [1:0] put_snoop;
    logic [2:0] l1_msg;
    logic       protocol_err;

    int checks = 0;
    int errors = 0;

    mesi_state_function #(.STATE_W(2), .CMD_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .present_state (present_state),
        .command       (command),
        .snoop_result  (snoop_result),
        .rsp_valid     (rsp_valid),
        .result_state  (result_state),
        .bus_op        (bus_op),
        .put_snoop     (put_snoop),
        .l1_msg        (l1_msg),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    // Rows: commands 0..6, clear, print_cache. Columns: M, E, S, I (encodings 0..3).
    int unsigned nxt_tab [0:8][0:3] = '{
        '{0,1,2,1}, '{0,0,0,0}, '{0,1,2,1}, '{0,1,3,3}, '{2,2,2,3},
        '{0,1,2,3}, '{3,3,3,3}, '{3,3,3,3}, '{0,1,2,3}};
    int unsigned bus_tab [0:8][0:3] = '{
        '{0,0,0,1}, '{0,0,3,4}, '{0,0,0,1}, '{0,0,0,0}, '{2,0,0,0},
        '{0,0,0,0}, '{2,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    int unsigned put_tab [0:8][0:3] = '{
        '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{2,1,1,0},
        '{0,0,0,0}, '{2,1,1,0}, '{0,0,0,0}, '{0,0,0,0}};
    int unsigned l1_tab  [0:8][0:3] = '{
        '{2,2,2,2}, '{0,0,0,0}, '{2,2,2,2}, '{0,0,3,0}, '{1,0,0,0},
        '{0,0,0,0}, '{4,3,3,0}, '{0,0,0,0}, '{0,0,0,0}};
    int unsigned err_tab [0:8][0:3] = '{
        '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{1,1,0,0}, '{0,0,0,0},
        '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};

    int unsigned m_valid, m_state, m_bus, m_put, m_l1, m_err;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int row_of(input int unsigned cmd);
        if (cmd <= 6) return int'(cmd);
        if (cmd == 8) return 7;
        if (cmd == 9) return 8;
        return -1;
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_state = 3; m_bus = 0; m_put = 0; m_l1 = 0; m_err = 0;
    endfunction

    function automatic void model_apply(input int unsigned st, input int unsigned cmd, input int unsigned snp);
        int r;
        r = row_of(cmd);
        if (r < 0) begin
            m_state = st; m_bus = 0; m_put = 0; m_l1 = 0; m_err = 1;
        end else begin
            m_state = nxt_tab[r][st];
            m_bus   = bus_tab[r][st];
            m_put   = put_tab[r][st];
            m_l1    = l1_tab[r][st];
            m_err   = err_tab[r][st];
            // A read miss lands in S when another cache answers HIT or HITM.
            if ((cmd == 0 || cmd == 2) && st == 3 && (snp == 1 || snp == 2)) m_state = 2;
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".rsp_valid"},    32'(rsp_valid),    m_valid);
        check({tag, ".result_state"}, 32'(result_state), m_state);
        check({tag, ".bus_op"},       32'(bus_op),       m_bus);
        check({tag, ".put_snoop"},    32'(put_snoop),    m_put);
        check({tag, ".l1_msg"},       32'(l1_msg),       m_l1);
        check({tag, ".protocol_err"}, 32'(protocol_err), m_err);
    endtask

    task automatic step(input string tag, input logic v, input logic [1:0] st,
                        input logic [3:0] c, input logic [1:0] sn);
        req_valid     = v;
        present_state = st;
        command       = c;
        snoop_result  = sn;
        @(posedge clk);
        #1;
        m_valid = 32'(v);
        if (v) model_apply(st, c, sn);
        compare_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; present_state = 2'd0; command = 4'd0; snoop_result = 2'd0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle0", 1'b0, 2'd0, 4'd1, 2'd0);
        step("idle1", 1'b0, 2'd2, 4'd6, 2'd1);

        // Directed cases from the coherence table.
        step("i_rd_nohit", 1'b1, 2'd3, 4'd0, 2'd0);
        step("i_rd_hitm",  1'b1, 2'd3, 4'd0, 2'd2);
        step("s_wr",       1'b1, 2'd2, 4'd1, 2'd1);
        step("i_wr",       1'b1, 2'd3, 4'd1, 2'd2);
        step("e_wr",       1'b1, 2'd1, 4'd1, 2'd0);
        step("m_srd",      1'b1, 2'd0, 4'd4, 2'd0);
        step("m_rfo",      1'b1, 2'd0, 4'd6, 2'd0);
        step("m_swr",      1'b1, 2'd0, 4'd5, 2'd0);
        step("hold",       1'b0, 2'd3, 4'd8, 2'd0);
        step("e_sinv",     1'b1, 2'd1, 4'd3, 2'd0);
        step("cmd7",       1'b1, 2'd2, 4'd7, 2'd0);
        step("m_clear",    1'b1, 2'd0, 4'd8, 2'd0);
        step("i_rd_snp3",  1'b1, 2'd3, 4'd2, 2'd3);

        // Full legal table sweep, back-to-back, plus the package function.
        for (int st = 0; st < 4; st++) begin
            for (int ci = 0; ci < 9; ci++) begin
                for (int sn = 0; sn < 3; sn++) begin
                    logic [3:0] c;
                    logic [3:0] fn;
                    c = (ci < 7) ? 4'(ci) : 4'(ci + 1);
                    step("sweep", 1'b1, 2'(st), c, 2'(sn));
                    fn = mesi_pkg::mesi_next(2'(st), c);
                    check("mesi_next", 32'(fn), nxt_tab[row_of(32'(c))][st]);
                end
            end
        end

        // Async reset with a request in flight: the request must be lost.
        step("pre_rst", 1'b1, 2'd0, 4'd4, 2'd0);
        req_valid = 1'b1; present_state = 2'd1; command = 4'd1; snoop_result = 2'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 2'd1, 4'd1, 2'd0);

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
